mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative HI/LO multiply/divide unit for the EXE stage of the MIPS pipeline.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ID/EXE and computes over WIDTH+1 cycles.
//  Drives BUSY to the hazard unit, which stalls IFID/IDEXE on MFHI/MFLO or any new HI/LO op while BUSY=1.
//  HI/LO feed the MFHI/MFLO path in EXE.
// PARAMETERS
//  WIDTH  32  operand width; product/remainder pair is 2*WIDTH wide; iteration count = WIDTH
// PORTS
//  CLOCK        in   1      pipeline clock, rising edge
//  RESET        in   1      asynchronous, active-low reset
//  START        in   1      issue OP with OPA/OPB this cycle
//  OP           in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//  OPA          in   WIDTH  rs value (multiplicand/dividend/MTxx data)
//  OPB          in   WIDTH  rt value (multiplier/divisor)
//  CANCEL       in   1      abort in-flight MUL/DIV (branch/exception squash)
//  HI           out  WIDTH  HI register
//  LO           out  WIDTH  LO register
//  BUSY         out  1      registered; 1 while a MUL/DIV is in flight
//  DONE         out  1      registered 1-cycle pulse: HI/LO just updated by MUL/DIV
//  DIV_BY_ZERO  out  1      registered; pulses with DONE when a DIV/DIVU divisor was 0
// BEHAVIOUR
//  Reset (async, RESET=0): state IDLE, HI=LO=0, BUSY=DONE=DIV_BY_ZERO=0, counter=0, operand regs=0.
//  States: IDLE -> MUL|DIV (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//  IDLE: START & OP=MULT/MULTU -> MUL; START & OP=DIV/DIVU -> DIV; latch |OPA|,|OPB| (signed ops),
//   raw operands (unsigned ops), result sign bits, counter=WIDTH-1.
//  MTHI/MTLO (IDLE only): HI/LO <= OPA at the sampling edge; no BUSY, no DONE.
//  MUL: radix-2 shift-add, one multiplier bit per cycle, 2*WIDTH accumulator.
//  DIV: restoring shift-subtract, one quotient bit per cycle.
//  Counter decrements each iteration; at counter=0 go to FIX.
//  FIX: conditional two's-complement negate, then write HI/LO; DONE=1 next cycle, BUSY=0 same cycle.
//   Signed MUL: negate 2*WIDTH product if signs differ.
//   Signed DIV: negate quotient if signs differ; remainder takes the dividend's sign.
//  Latency: START sampled at end of cycle 0; BUSY=1 cycles 1..WIDTH+1.
//   New HI/LO and DONE=1 in cycle WIDTH+2 (cycle 34 at WIDTH=32); BUSY=0 that cycle.
//  Width rules: LO=product[WIDTH-1:0], HI=product[2W-1:W]; DIV: LO=quotient, HI=remainder.
//  Divide by zero: no iteration change; HI=OPA, LO=all ones, DIV_BY_ZERO=1 with DONE.
//  Signed overflow (-2^(W-1) / -1): LO=0x80000000, HI=0, no flag.
//  START while BUSY: ignored entirely, including MTHI/MTLO; the hazard unit must prevent it.
//  CANCEL while BUSY: next edge -> IDLE, BUSY=0, HI/LO keep prior values, no DONE; START same cycle ignored.
//  CANCEL while IDLE: ignored; a coincident START is accepted.
//  DONE cycle is IDLE: a START in the DONE cycle is accepted (back-to-back issue).
//  Reset mid-operation: immediate return to reset state, partial result discarded.
// TESTING
//  1. MULTU FFFFFFFF*FFFFFFFF -> cycle 34: HI=FFFFFFFE LO=00000001, DONE 1 cycle, BUSY cycles 1..33.
//  2. MULT FFFFFFFD(-3)*00000007 -> HI=FFFFFFFF LO=FFFFFFEB; MULT 80000000*80000000 -> HI=40000000 LO=0.
//  3. DIV FFFFFFF9(-7)/2 -> LO=FFFFFFFD HI=FFFFFFFF; DIVU 100/7 -> LO=14 HI=2.
//  4. DIV 5/0 -> HI=5 LO=FFFFFFFF DIV_BY_ZERO=1 with DONE; DIV 80000000/FFFFFFFF -> LO=80000000 HI=0.
//  5. MULT start, CANCEL in cycle 10 -> BUSY=0 cycle 11, HI/LO unchanged, no DONE;
//     MTHI during BUSY ignored; MTLO 1234 while idle -> LO=1234 next cycle.
//  6. RESET low in cycle 15 of a DIV -> HI=LO=0, BUSY=0 immediately; DIVU 9/3 after release -> LO=3 HI=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit for the EXE stage.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring shift-subtract.
// Each takes WIDTH iterations plus one sign-fix cycle. MTHI/MTLO write HI/LO
// directly, and only while the unit is idle.
// Ports:
//   CLOCK        rising-edge pipeline clock
//   RESET        asynchronous, active-low reset
//   START        issue OP with OPA/OPB this cycle (ignored while BUSY)
//   OP           000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   OPA/OPB      rs / rt operand values
//   CANCEL       abort an in-flight MUL/DIV (ignored while idle)
//   HI/LO        result registers
//   BUSY         registered, high while a MUL/DIV is in flight
//   DONE         registered one-cycle pulse when a MUL/DIV updates HI/LO
//   DIV_BY_ZERO  registered, pulses with DONE for a zero divisor
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] OPA,
  input  logic [WIDTH-1:0] OPB,
  input  logic             CANCEL,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_BY_ZERO
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc_hi, acc_hi_nx;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo, acc_lo_nx;   // multiplier bits / dividend then quotient
  logic [WIDTH-1:0] opd, opd_nx;         // |multiplicand| or |divisor|
  logic [WIDTH-1:0] a_save, a_save_nx;   // raw dividend, returned in HI on divide by zero
  logic [CW-1:0]    cnt, cnt_nx;
  logic             is_div, is_div_nx;
  logic             neg_res, neg_res_nx;
  logic             neg_rem, neg_rem_nx;
  logic             div_zero, div_zero_nx;
  logic [WIDTH-1:0] hi_q, hi_nx, lo_q, lo_nx;
  logic             busy_q, busy_nx, done_q, done_nx, dbz_q, dbz_nx;

  logic             is_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_part;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    state_nx    = state;
    acc_hi_nx   = acc_hi;
    acc_lo_nx   = acc_lo;
    opd_nx      = opd;
    a_save_nx   = a_save;
    cnt_nx      = cnt;
    is_div_nx   = is_div;
    neg_res_nx  = neg_res;
    neg_rem_nx  = neg_rem;
    div_zero_nx = div_zero;
    hi_nx       = hi_q;
    lo_nx       = lo_q;
    busy_nx     = busy_q;
    done_nx     = 1'b0;
    dbz_nx      = 1'b0;

    is_signed = ~OP[0];
    abs_a     = (is_signed && OPA[WIDTH-1]) ? -OPA : OPA;
    abs_b     = (is_signed && OPB[WIDTH-1]) ? -OPB : OPB;

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);

    // Restoring step: shift the next dividend bit into the partial remainder.
    // When the subtraction succeeds the difference is below the divisor, so
    // the low WIDTH bits hold it exactly.
    div_part = {acc_hi, acc_lo[WIDTH-1]};
    div_ge   = (div_part >= {1'b0, opd});
    div_diff = div_part[WIDTH-1:0] - opd;

    prod     = {acc_hi, acc_lo};
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -acc_lo : acc_lo;
    rem_fix  = neg_rem ? -acc_hi : acc_hi;

    case (state)
      S_IDLE: begin
        if (START) begin
          case (OP)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              state_nx    = OP[1] ? S_DIV : S_MUL;
              is_div_nx   = OP[1];
              acc_hi_nx   = '0;
              acc_lo_nx   = OP[1] ? abs_a : abs_b;
              opd_nx      = OP[1] ? abs_b : abs_a;
              a_save_nx   = OPA;
              cnt_nx      = CW'(WIDTH - 1);
              neg_res_nx  = is_signed & (OPA[WIDTH-1] ^ OPB[WIDTH-1]);
              neg_rem_nx  = is_signed & OPA[WIDTH-1];
              div_zero_nx = OP[1] & (OPB == '0);
              busy_nx     = 1'b1;
            end
            3'b100:  hi_nx = OPA;
            3'b101:  lo_nx = OPA;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (CANCEL) begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
        end else begin
          if (state == S_MUL) begin
            {acc_hi_nx, acc_lo_nx} = {mul_sum, acc_lo[WIDTH-1:1]};
          end else begin
            acc_hi_nx = div_ge ? div_diff : div_part[WIDTH-1:0];
            acc_lo_nx = {acc_lo[WIDTH-2:0], div_ge};
          end
          if (cnt == '0) state_nx = S_FIX;
          else           cnt_nx   = cnt - 1'b1;
        end
      end
      S_FIX: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
        if (!CANCEL) begin
          done_nx = 1'b1;
          if (!is_div) begin
            {hi_nx, lo_nx} = prod_fix;
          end else if (div_zero) begin
            hi_nx  = a_save;
            lo_nx  = '1;
            dbz_nx = 1'b1;
          end else begin
            hi_nx = rem_fix;
            lo_nx = quo_fix;
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opd      <= '0;
      a_save   <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      acc_hi   <= acc_hi_nx;
      acc_lo   <= acc_lo_nx;
      opd      <= opd_nx;
      a_save   <= a_save_nx;
      cnt      <= cnt_nx;
      is_div   <= is_div_nx;
      neg_res  <= neg_res_nx;
      neg_rem  <= neg_rem_nx;
      div_zero <= div_zero_nx;
      hi_q     <= hi_nx;
      lo_q     <= lo_nx;
      busy_q   <= busy_nx;
      done_q   <= done_nx;
      dbz_q    <= dbz_nx;
    end
  end

  assign HI          = hi_q;
  assign LO          = lo_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): directed vectors, random
// MUL/DIV against an arithmetic reference, cancel, back-to-back, mid-op reset.
module tb_mult_div_unit;
  localparam int unsigned W = 32;

  logic         CLOCK = 1'b0;
  logic         RESET, START, CANCEL;
  logic [2:0]   OP;
  logic [W-1:0] OPA, OPB, HI, LO;
  logic         BUSY, DONE, DIV_BY_ZERO;

  int checks = 0;
  int failures = 0;

  always #5 CLOCK = ~CLOCK;

  mult_div_unit #(.WIDTH(W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
    .CANCEL(CANCEL), .HI(HI), .LO(LO), .BUSY(BUSY), .DONE(DONE),
    .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  // Reference: plain 64-bit arithmetic; SV signed division truncates toward
  // zero and the remainder follows the dividend, as MIPS requires.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    longint sa, sb;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t  = '0;
    dz = 1'b0;
    case (op)
      3'd0: t = sa * sb;
      3'd1: t = {32'd0, a} * {32'd0, b};
      3'd2: if (b == 0) t = {a, 32'hFFFF_FFFF};
            else begin t[31:0] = 32'(sa / sb); t[63:32] = 32'(sa % sb); end
      3'd3: if (b == 0) t = {a, 32'hFFFF_FFFF};
            else t = {a % b, a / b};
      default: ;
    endcase
    if (op[1] && b == 0) dz = 1'b1;
    hi = t[63:32];
    lo = t[31:0];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h0;
      1: pick = 32'hFFFF_FFFF;
      2: pick = 32'h8000_0000;
      3: pick = $urandom_range(0, 15);
      default: pick = $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Issues one op and observes it until DONE (bounded); returns in the DONE cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output bit busy_ok, output logic [31:0] hi,
                        output logic [31:0] lo, output bit dz, output bit busy_at_done);
    START = 1'b1; OP = op; OPA = a; OPB = b;
    step();
    START = 1'b0; CANCEL = 1'b0;
    busy_ok = 1'b1; done_cyc = -1; hi = '0; lo = '0; dz = 1'b0; busy_at_done = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (DONE) begin
        done_cyc = c; hi = HI; lo = LO; dz = DIV_BY_ZERO; busy_at_done = BUSY;
        break;
      end
      if (!BUSY) busy_ok = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; START = 1'b0; CANCEL = 1'b0; OP = '0; OPA = '0; OPB = '0;
    #12;
    checks++; if (HI !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected 00000000", HI); end
    checks++; if (LO !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected 00000000", LO); end
    checks++; if ({BUSY, DONE, DIV_BY_ZERO} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b expected 000", {BUSY, DONE, DIV_BY_ZERO}); end
    RESET = 1'b1;
    step();
    checks++; if ({BUSY, DONE, HI, LO} !== '0) begin
      failures++; $display("FAIL reset_release: got %b/%b %h %h expected idle zeros", BUSY, DONE, HI, LO); end
  endtask

  typedef struct { logic [2:0] op; logic [31:0] a, b, ehi, elo; bit edz; } vec_t;

  task automatic test_directed();
    vec_t v[7];
    int dc; bit bok, dz, bad; logic [31:0] hi, lo;
    v[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    v[1] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    v[2] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    v[3] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    v[4] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    v[5] = '{3'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    v[6] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, dc, bok, hi, lo, dz, bad);
      checks++; if (dc !== 34) begin failures++; $display("FAIL dir%0d_done_cycle: got %0d expected 34", i, dc); end
      checks++; if (bok !== 1'b1) begin failures++; $display("FAIL dir%0d_busy_window: got %b expected 1", i, bok); end
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL dir%0d_busy_at_done: got %b expected 0", i, bad); end
      checks++; if ({hi, lo} !== {v[i].ehi, v[i].elo}) begin
        failures++; $display("FAIL dir%0d_hilo: got %h_%h expected %h_%h", i, hi, lo, v[i].ehi, v[i].elo); end
      checks++; if (dz !== v[i].edz) begin failures++; $display("FAIL dir%0d_dbz: got %b expected %b", i, dz, v[i].edz); end
      step();
      checks++; if ({DONE, DIV_BY_ZERO} !== 2'b00) begin
        failures++; $display("FAIL dir%0d_pulse_width: got %b expected 00", i, {DONE, DIV_BY_ZERO}); end
    end
  endtask

  task automatic test_random();
    int dc; bit bok, dz, bad, edz; logic [31:0] hi, lo, ehi, elo, a, b; logic [2:0] op;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 3));
      a = pick(); b = pick();
      model(op, a, b, ehi, elo, edz);
      run_op(op, a, b, dc, bok, hi, lo, dz, bad);
      checks++; if (dc !== 34) begin failures++; $display("FAIL rand%0d_done_cycle: got %0d expected 34", n, dc); end
      checks++; if ({hi, lo} !== {ehi, elo}) begin
        failures++; $display("FAIL rand%0d_hilo op=%0d a=%h b=%h: got %h_%h expected %h_%h", n, op, a, b, hi, lo, ehi, elo); end
      checks++; if (dz !== edz) begin failures++; $display("FAIL rand%0d_dbz: got %b expected %b", n, dz, edz); end
    end
  endtask

  task automatic test_cancel();
    int dc; bit bok, dz, bad, saw_done; logic [31:0] hi, lo;
    START = 1'b1; OP = 3'd4; OPA = 32'hAAAA_5555; step();
    OP = 3'd5; OPA = 32'h5555_AAAA; step();
    START = 1'b1; OP = 3'd0; OPA = $urandom; OPB = $urandom; step();
    for (int c = 1; c <= 10; c++) begin
      START  = (c == 5 || c == 10);
      OP     = (c == 5) ? 3'd4 : 3'd5;
      OPA    = 32'hDEAD_BEEF;
      CANCEL = (c == 10);
      step();
    end
    START = 1'b0; CANCEL = 1'b0;
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL cancel_busy: got %b expected 0", BUSY); end
    checks++; if ({HI, LO} !== {32'hAAAA_5555, 32'h5555_AAAA}) begin
      failures++; $display("FAIL cancel_hilo: got %h_%h expected aaaa5555_5555aaaa", HI, LO); end
    saw_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      saw_done |= DONE;
      step();
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL cancel_no_done: got %b expected 0", saw_done); end
    START = 1'b1; OP = 3'd5; OPA = 32'h1234; step();
    START = 1'b0;
    checks++; if ({HI, LO} !== {32'hAAAA_5555, 32'h0000_1234}) begin
      failures++; $display("FAIL mtlo_idle: got %h_%h expected aaaa5555_00001234", HI, LO); end
    checks++; if ({BUSY, DONE} !== 2'b00) begin failures++; $display("FAIL mtlo_flags: got %b expected 00", {BUSY, DONE}); end
    CANCEL = 1'b1;
    run_op(3'd3, 32'd100, 32'd7, dc, bok, hi, lo, dz, bad);
    checks++; if (dc !== 34) begin failures++; $display("FAIL idle_cancel_done_cycle: got %0d expected 34", dc); end
    checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin
      failures++; $display("FAIL idle_cancel_hilo: got %h_%h expected 00000002_0000000e", hi, lo); end
    step();
  endtask

  task automatic test_back_to_back();
    int dc1, dc2; bit bok1, bok2, dz1, dz2, bad1, bad2, edz1, edz2;
    logic [31:0] hi1, lo1, hi2, lo2, ehi1, elo1, ehi2, elo2, a1, b1, a2, b2;
    for (int n = 0; n < 3; n++) begin
      a1 = pick(); b1 = pick(); a2 = pick(); b2 = pick();
      model(3'd0, a1, b1, ehi1, elo1, edz1);
      model(3'd2, a2, b2, ehi2, elo2, edz2);
      run_op(3'd0, a1, b1, dc1, bok1, hi1, lo1, dz1, bad1);
      run_op(3'd2, a2, b2, dc2, bok2, hi2, lo2, dz2, bad2);
      checks++; if ({hi1, lo1} !== {ehi1, elo1}) begin
        failures++; $display("FAIL b2b%0d_first_hilo: got %h_%h expected %h_%h", n, hi1, lo1, ehi1, elo1); end
      checks++; if (dc2 !== 34 || bok2 !== 1'b1) begin
        failures++; $display("FAIL b2b%0d_second_timing: got cycle %0d busy_ok %b expected 34 1", n, dc2, bok2); end
      checks++; if ({hi2, lo2, dz2} !== {ehi2, elo2, edz2}) begin
        failures++; $display("FAIL b2b%0d_second_hilo: got %h_%h/%b expected %h_%h/%b", n, hi2, lo2, dz2, ehi2, elo2, edz2); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int dc; bit bok, dz, bad; logic [31:0] hi, lo;
    START = 1'b1; OP = 3'd4; OPA = 32'h1111_2222; step();
    OP = 3'd5; OPA = 32'h3333_4444; step();
    OP = 3'd2; OPA = $urandom; OPB = 32'h0000_0013; step();
    START = 1'b0;
    for (int c = 1; c < 15; c++) step();
    #2 RESET = 1'b0;
    #1;
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", BUSY); end
    checks++; if ({HI, LO} !== 64'h0) begin failures++; $display("FAIL midreset_hilo: got %h_%h expected 0_0", HI, LO); end
    @(posedge CLOCK);
    #3 RESET = 1'b1;
    step();
    checks++; if ({BUSY, DONE, HI, LO} !== '0) begin
      failures++; $display("FAIL midreset_after: got %b/%b %h_%h expected idle zeros", BUSY, DONE, HI, LO); end
    run_op(3'd3, 32'd9, 32'd3, dc, bok, hi, lo, dz, bad);
    checks++; if (dc !== 34) begin failures++; $display("FAIL midreset_divu_cycle: got %0d expected 34", dc); end
    checks++; if ({hi, lo} !== {32'd0, 32'd3}) begin
      failures++; $display("FAIL midreset_divu_hilo: got %h_%h expected 00000000_00000003", hi, lo); end
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
